aes_sub_bytes_engine: RTL and testbench
=======================================

# aes_sub_bytes_engine

Parametrised, sequential SubBytes / InvSubBytes engine for the AES datapath. It accepts one 128-bit AES state per valid/ready handshake and substitutes its 16 bytes through LANES parallel S-box lanes over 16/LANES cycles. It returns the result on a valid/ready output port. Forward or inverse substitution is selected per block, so the round controller can use one instance for both encryption and decryption.

## Interface
- LANES, 4: S-box lanes used per cycle. Legal values are 1, 2, 4, 8, 16; any other value causes an elaboration error ($error).
- BEATS, 16/LANES: derived localparam giving the number of substitution cycles per block. It is not overridable.

- clk  in  1  Single clock. All state updates on the rising edge.
- rst_n  in  1  Reset, asynchronous and active-low.
- clear  in  1  Synchronous abort. Drops any in-flight block and returns to IDLE.
- in_valid  in  1  Input state is valid.
- in_ready  out  1  Engine can accept a block. High only in IDLE.
- in_state  in  128  AES state. Byte k occupies in_state[127-8k -: 8]; byte 0 is the MSB byte.
- in_inv  in  1  Selects the mode: 0 = forward S-box, 1 = inverse S-box. Sampled at acceptance.
- out_valid  out  1  Result is valid. High only in DONE.
- out_ready  in  1  Downstream accepts the result.
- out_state  out  128  Substituted state, using the same byte order as in_state.
- busy  out  1  High in RUN or DONE.

## Operation
- Lane function:
  - Forward mode applies the FIPS-197 S-box.
  - Inverse mode applies the FIPS-197 inverse S-box.
  - Each lane is combinational. Implementation may be a case table or GF(2^8) inversion plus affine transform.
  - Results must be bit-exact to the FIPS-197 tables for all 256 inputs.
- Registers:
  - work[127:0]: working state.
  - inv_q: latched mode.
  - beat: counter of width max(1, clog2(BEATS)).
  - state: FSM in {IDLE, RUN, DONE}.
- IDLE:
  - in_ready=1.
  - On in_valid, load work←in_state, inv_q←in_inv, beat←0, and go to RUN.
- RUN:
  - Each cycle, bytes beat*LANES … beat*LANES+LANES-1 of work are replaced in place by their lane outputs.
  - beat increments each cycle.
  - When beat==BEATS-1, the last group is written and the FSM goes to DONE. The beat counter does not advance past BEATS-1.
  - in_valid is ignored in this state; no input is accepted.
- DONE:
  - out_valid=1 and out_state=work.
  - On out_ready, go to IDLE.
  - While out_ready=0, work and out_valid hold indefinitely.
- clear:
  - Has priority over every transition, in any state.
  - Next state is IDLE and beat←0. The work contents are don't-care, but out_valid must drop.
  - If clear and in_valid are both high in IDLE, the input is NOT accepted.
- Mode is fixed per block. Changes on in_inv after acceptance have no effect.
- out_state drives work directly. Its value is defined only while out_valid=1.

## Timing
- Reset values (asserted asynchronously): state=IDLE, in_ready=1, out_valid=0, busy=0, work=0, out_state=0, beat=0, inv_q=0.
- Reset mid-operation: the block is lost; no partial output is produced.
- Latency: for acceptance at edge T0, substitutions happen at edges T1…T_BEATS and out_valid rises after edge T_BEATS.
  - LANES=16: result one cycle after acceptance.
  - LANES=1: result 16 cycles after acceptance.
- Output handshake completes at the first edge where out_valid & out_ready. in_ready rises in the following cycle.
- Maximum throughput is one block per BEATS+2 cycles, with out_ready held high.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready to either output.

## Test plan
- FIPS-197 round-1 vector, LANES=4, in_inv=0: in_state=128'h193de3bea0f4e22b9ac68d2ae9f84808 → out_state=128'hd42711aee0bf98f1b8b45de51e415230. out_valid must rise exactly 4 cycles after acceptance.
- Inverse round trip: feed 128'hd42711aee0bf98f1b8b45de51e415230 with in_inv=1 → 128'h193de3bea0f4e22b9ac68d2ae9f84808. Repeat for LANES=1, 2, 8, 16 with latency 16, 8, 2, 1 respectively.
- Exhaustive lane check: send 16 blocks covering bytes 00…FF in both modes and compare against the reference tables. Spot values: S(00)=63, S(53)=ED, S(FF)=16, S⁻¹(63)=00, S⁻¹(16)=FF.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid and out_state must stay stable, in_ready=0, and in_valid pulses are ignored. Releasing out_ready gives one handshake, then in_ready=1 in the next cycle.
- clear during RUN at beat 1 (LANES=4): FSM goes to IDLE with out_valid never asserted. A fresh block accepted afterwards produces the correct result. clear together with in_valid in IDLE results in no acceptance.
- Async reset asserted mid-RUN and mid-DONE: outputs immediately take their reset values (in_ready=1, out_valid=0, busy=0, out_state=0). After rst_n deasserts, a normal block completes correctly.

Source files
------------

// File: rtl/aes_sub_bytes_engine.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_engine
// Sequential AES SubBytes / InvSubBytes engine. One 128-bit state is accepted
// per input handshake. Its 16 bytes are substituted in place, LANES bytes per
// cycle over BEATS = 16/LANES cycles. The result is then offered on an output
// handshake. The forward or inverse S-box is chosen per block.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous abort back to IDLE (highest priority)
//   in_valid/ready  input handshake (in_ready high only in IDLE)
//   in_state        128-bit AES state, byte k at [127-8k -: 8]
//   in_inv          0 = forward S-box, 1 = inverse S-box (sampled on accept)
//   out_valid/ready output handshake (out_valid high only in DONE)
//   out_state       substituted state, same byte order as in_state
//   busy            high in RUN or DONE
// ---------------------------------------------------------------------------
module aes_sub_bytes_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned BEATS = 16 / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
        $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    // One S-box lane; the field inverter is shared between both directions
    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        logic [7:0] g;
        g = gf_inv(inv ? inv_affine(b) : b);
        return inv ? g : fwd_affine(g);
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   work_q, work_d;
    logic           inv_q, inv_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;

    // Next-state, in-place substitution and output decode
    always_comb begin
        int unsigned pos;
        state_d = state_q;
        work_d  = work_q;
        inv_d   = inv_q;
        beat_d  = beat_q;
        pos     = 0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    inv_d   = in_inv;
                    beat_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    pos = 32'(beat_q) * LANES + l;
                    work_d[127 - 8*pos -: 8] = sub_byte(work_q[127 - 8*pos -: 8], inv_q);
                end
                if (beat_q == BW'(BEATS - 1)) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any transition, including a same-cycle acceptance
        if (clear) begin
            state_d = IDLE;
            beat_d  = '0;
            work_d  = work_q;
            inv_d   = inv_q;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            inv_q       <= 1'b0;
            beat_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            inv_q       <= inv_d;
            beat_q      <= beat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_sub_bytes_engine
// Five engines (LANES = 1, 2, 4, 8, 16) share clock, reset, clear and input
// data. Each has its own valid/ready pair. Expected results come from the
// FIPS-197 S-box table held below. The inverse table is derived by inverting
// the forward table.
// ---------------------------------------------------------------------------
module tb_aes_sub_bytes_engine;

    localparam int NDUT = 5;
    localparam int MAIN = 2;   // LANES = 4 instance

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         in_inv;
    logic [127:0] in_state;
    logic         in_valid_a  [NDUT];
    logic         out_ready_a [NDUT];
    logic         in_ready_a  [NDUT];
    logic         out_valid_a [NDUT];
    logic         busy_a      [NDUT];
    logic [127:0] out_state_a [NDUT];

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes_sub_bytes_engine #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_state  (in_state),
            .in_inv    (in_inv),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );
    end

    typedef struct {
        int           idx;
        logic [127:0] st;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = st[127 - 8*k -: 8];
            r[127 - 8*k -: 8] = inv ? isbox[b] : sbox[b];
        end
        return r;
    endfunction

    // Accept one block on instance idx, measure latency, hold the result for
    // 'hold' cycles under backpressure, then complete the handshake.
    task automatic run_block(input int idx, input logic [127:0] st, input logic inv,
                             input logic [127:0] exp, input int hold, input string name);
        int n;
        n = 0;
        while (!in_ready_a[idx] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({name, " ready_before"}, 128'(in_ready_a[idx]), 128'd1);
        out_ready_a[idx] = (hold == 0);
        in_state = st;
        in_inv   = inv;
        in_valid_a[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[idx] = 1'b0;
        // mode and data changes after acceptance must have no effect
        in_inv   = ~inv;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!out_valid_a[idx] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({name, " latency"}, 128'(n), 128'(16 >> idx));
        check({name, " data"}, out_state_a[idx], exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({name, " hold_valid"}, 128'(out_valid_a[idx]), 128'd1);
            check({name, " hold_data"}, out_state_a[idx], exp);
        end
        out_ready_a[idx] = 1'b1;
        @(posedge clk); #1;
        check({name, " post_valid"}, 128'(out_valid_a[idx]), 128'd0);
        check({name, " post_ready"}, 128'(in_ready_a[idx]), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [8];
        logic [2047:0] tab;
        logic [127:0] st;
        logic [127:0] exp;
        logic         inv;
        int           idx;
        int           n;

        tab = SBOX_TAB;
        for (int i = 0; i < 256; i++) sbox[i] = tab[2047 - 8*i -: 8];
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);

        vecs[0] = '{MAIN, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[1] = '{MAIN, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[2] = '{0,    128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[3] = '{1,    128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[4] = '{3,    128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[5] = '{4,    128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[6] = '{MAIN, 128'h0053ff00000000000000000000000000, 1'b0, 128'h63ed1663636363636363636363636363};
        vecs[7] = '{4,    128'h63166363636363636363636363636363, 1'b1, 128'h00ff0000000000000000000000000000};

        rst_n = 1'b0;
        clear = 1'b0;
        in_inv = 1'b0;
        in_state = '0;
        for (int i = 0; i < NDUT; i++) begin
            in_valid_a[i]  = 1'b0;
            out_ready_a[i] = 1'b1;
        end
        #12;
        check("rst in_ready", 128'(in_ready_a[MAIN]), 128'd1);
        check("rst out_valid", 128'(out_valid_a[MAIN]), 128'd0);
        check("rst busy", 128'(busy_a[MAIN]), 128'd0);
        check("rst out_state", out_state_a[MAIN], 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // directed vectors
        for (int v = 0; v < 8; v++)
            run_block(vecs[v].idx, vecs[v].st, vecs[v].inv, vecs[v].exp, 0, $sformatf("vec%0d", v));

        // every byte value in both modes, spread across lane counts
        for (int b = 0; b < 16; b++) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 16; k++) st[127 - 8*k -: 8] = 8'(16*b + k);
                run_block((2*b + m) % NDUT, st, m[0], model(st, m[0]), 0, $sformatf("exh%0d_%0d", b, m));
            end
        end

        // randomized blocks with random backpressure
        for (int r = 0; r < 30; r++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(1));
            idx = int'($urandom_range(NDUT - 1));
            run_block(idx, st, inv, model(st, inv), int'($urandom_range(3)), $sformatf("rnd%0d", r));
        end

        // backpressure: 10 held cycles with ignored in_valid pulses
        st  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        exp = 128'hd42711aee0bf98f1b8b45de51e415230;
        out_ready_a[MAIN] = 1'b0;
        in_state = st; in_inv = 1'b0; in_valid_a[MAIN] = 1'b1;
        @(posedge clk); #1; in_valid_a[MAIN] = 1'b0;
        n = 0;
        while (!out_valid_a[MAIN] && n < 40) begin @(posedge clk); #1; n++; end
        check("bp latency", 128'(n), 128'd4);
        for (int h = 0; h < 10; h++) begin
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_valid_a[MAIN] = h[0];
            @(posedge clk); #1;
            check("bp valid", 128'(out_valid_a[MAIN]), 128'd1);
            check("bp data", out_state_a[MAIN], exp);
            check("bp in_ready", 128'(in_ready_a[MAIN]), 128'd0);
        end
        in_valid_a[MAIN] = 1'b0;
        out_ready_a[MAIN] = 1'b1;
        @(posedge clk); #1;
        check("bp release valid", 128'(out_valid_a[MAIN]), 128'd0);
        check("bp release ready", 128'(in_ready_a[MAIN]), 128'd1);
        @(posedge clk); #1;
        check("bp no extra busy", 128'(busy_a[MAIN]), 128'd0);

        // clear at beat 1
        in_state = st; in_inv = 1'b0; in_valid_a[MAIN] = 1'b1;
        @(posedge clk); #1; in_valid_a[MAIN] = 1'b0;   // accepted, beat 0
        @(posedge clk); #1;                            // beat 1
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr in_ready", 128'(in_ready_a[MAIN]), 128'd1);
        check("clr busy", 128'(busy_a[MAIN]), 128'd0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid_a[MAIN]) n++;
        end
        check("clr no out_valid", 128'(n), 128'd0);
        // clear together with in_valid: no acceptance
        clear = 1'b1; in_valid_a[MAIN] = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid_a[MAIN] = 1'b0;
        check("clr+valid busy", 128'(busy_a[MAIN]), 128'd0);
        check("clr+valid in_ready", 128'(in_ready_a[MAIN]), 128'd1);
        run_block(MAIN, exp, 1'b1, st, 0, "after_clear");

        // async reset mid-RUN
        in_state = st; in_inv = 1'b0; in_valid_a[MAIN] = 1'b1;
        @(posedge clk); #1; in_valid_a[MAIN] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rstrun in_ready", 128'(in_ready_a[MAIN]), 128'd1);
        check("rstrun out_valid", 128'(out_valid_a[MAIN]), 128'd0);
        check("rstrun busy", 128'(busy_a[MAIN]), 128'd0);
        check("rstrun out_state", out_state_a[MAIN], 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(MAIN, st, 1'b0, exp, 0, "after_rst_run");

        // async reset mid-DONE
        out_ready_a[MAIN] = 1'b0;
        in_state = st; in_inv = 1'b0; in_valid_a[MAIN] = 1'b1;
        @(posedge clk); #1; in_valid_a[MAIN] = 1'b0;
        n = 0;
        while (!out_valid_a[MAIN] && n < 40) begin @(posedge clk); #1; n++; end
        check("rstdone reached", 128'(out_valid_a[MAIN]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("rstdone in_ready", 128'(in_ready_a[MAIN]), 128'd1);
        check("rstdone out_valid", 128'(out_valid_a[MAIN]), 128'd0);
        check("rstdone busy", 128'(busy_a[MAIN]), 128'd0);
        check("rstdone out_state", out_state_a[MAIN], 128'd0);
        out_ready_a[MAIN] = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(MAIN, st, 1'b0, exp, 0, "after_rst_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
